// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC and the fetch-state encoding.
package pc_fetch_unit_pkg;

  localparam int unsigned DefAddrW    = 16;
  localparam int unsigned DefInstrW   = 16;
  localparam logic [15:0] DefResetPc  = 16'h0000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/pc_incrementer.sv
// Modulo-2^Width increment by one with carry-out.
module pc_incrementer #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] value_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);

  assign {carry_o, sum_o} = {1'b0, value_i} + {{Width{1'b0}}, 1'b1};

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, single-outstanding imem request,
// redirect handling and a one-entry valid/ready buffer toward decode.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W   = DefAddrW,
  parameter int unsigned        INSTR_W  = DefInstrW,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DefResetPc)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [ADDR_W-1:0]  dec_pc_next,
  output logic               pc_wrap
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic               dec_valid_q, dec_valid_d;
  logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
  logic [ADDR_W-1:0]  dec_pc_q, dec_pc_d;
  logic [ADDR_W-1:0]  dec_pc_next_q, dec_pc_next_d;
  logic               pc_wrap_q, pc_wrap_d;

  logic [ADDR_W-1:0]  pc_inc;
  logic               pc_carry;
  logic [ADDR_W-1:0]  fill_pc, fill_pc_inc;
  logic               unused_fill_carry;
  logic               buffer_free;
  logic               fill;

  pc_incrementer #(
    .Width (ADDR_W)
  ) u_pc_inc (
    .value_i (pc_q),
    .sum_o   (pc_inc),
    .carry_o (pc_carry)
  );

  pc_incrementer #(
    .Width (ADDR_W)
  ) u_link_inc (
    .value_i (fill_pc),
    .sum_o   (fill_pc_inc),
    .carry_o (unused_fill_carry)
  );

  assign buffer_free = !dec_valid_q || dec_ready;
  assign imem_req    = ((state_q == StReq) && buffer_free) || (state_q == StWait) ||
                       (state_q == StDiscard);
  assign imem_addr   = (state_q == StReq) ? pc_q : fetch_addr_q;
  assign fill_pc     = imem_addr;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    dec_valid_d   = dec_valid_q && !dec_ready;
    dec_instr_d   = dec_instr_q;
    dec_pc_d      = dec_pc_q;
    dec_pc_next_d = dec_pc_next_q;
    pc_wrap_d     = 1'b0;
    fill          = 1'b0;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_req) begin
          if (imem_ack) begin
            fill = 1'b1;
          end else begin
            fetch_addr_d = pc_q;
            state_d      = StWait;
          end
        end
      end
      StWait: begin
        if (imem_ack) begin
          fill    = 1'b1;
          state_d = StReq;
        end
      end
      StDiscard: begin
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over fill: data returning this cycle belongs to the old path.
    if (redirect_valid && (state_q != StIdle)) begin
      fill        = 1'b0;
      pc_d        = redirect_pc;
      dec_valid_d = 1'b0;
      if (imem_req && !imem_ack) begin
        fetch_addr_d = imem_addr;
        state_d      = StDiscard;
      end else begin
        state_d = StReq;
      end
    end

    if (fill) begin
      dec_valid_d   = 1'b1;
      dec_instr_d   = imem_rdata;
      dec_pc_d      = fill_pc;
      dec_pc_next_d = fill_pc_inc;
      pc_d          = pc_inc;
      pc_wrap_d     = pc_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC;
      dec_valid_q   <= 1'b0;
      dec_instr_q   <= '0;
      dec_pc_q      <= '0;
      dec_pc_next_q <= '0;
      pc_wrap_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      dec_valid_q   <= dec_valid_d;
      dec_instr_q   <= dec_instr_d;
      dec_pc_q      <= dec_pc_d;
      dec_pc_next_q <= dec_pc_next_d;
      pc_wrap_q     <= pc_wrap_d;
    end
  end

  assign dec_valid   = dec_valid_q;
  assign dec_instr   = dec_instr_q;
  assign dec_pc      = dec_pc_q;
  assign dec_pc_next = dec_pc_next_q;
  assign pc_wrap     = pc_wrap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: latency-configurable memory model, PC/buffer
// scoreboard, a per-cycle vector table and hand-written corner sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic [15:0] dec_pc_next;
  logic        pc_wrap;

  pc_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pc_next    (dec_pc_next),
    .pc_wrap        (pc_wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcn;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  ent_t        sb[$];
  vec_t        vecs[12];
  int          nvec;
  int          nerr;
  int unsigned lat;
  int unsigned mem_cnt;
  logic [15:0] exp_pc;
  logic [15:0] held_pc;
  logic [15:0] last_dec_pc;
  logic        discard;
  logic        outstanding;
  logic        alive;
  logic        wrap_exp;
  int          valid_cnt;
  int          wrap_cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, answer memory, compare, then advance the model
  // to match the coming rising edge.
  task automatic step(input logic rst, input logic rdy, input logic rv, input logic [15:0] rp);
    logic exp_req;
    @(negedge clk);
    rst_n          = rst;
    dec_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    imem_ack   = rst && (imem_req === 1'b1) && (mem_cnt >= lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 16'h0000;
    #1;
    exp_req = (alive && (sb.size() == 0 || rdy)) || outstanding;
    chk("imem_req", 16'(imem_req), 16'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, discard ? held_pc : exp_pc);
    chk("dec_valid", 16'(dec_valid), 16'(sb.size() != 0));
    chk("pc_wrap", 16'(pc_wrap), 16'(wrap_exp));
    if (sb.size() != 0) begin
      chk("dec_instr", dec_instr, sb[0].instr);
      chk("dec_pc", dec_pc, sb[0].pc);
      chk("dec_pc_next", dec_pc_next, sb[0].pcn);
    end
    if (dec_valid === 1'b1) begin
      valid_cnt++;
      last_dec_pc = dec_pc;
    end
    if (pc_wrap === 1'b1) wrap_cnt++;
    if (sb.size() != 0 && rdy) void'(sb.pop_front());

    wrap_exp = 1'b0;
    if (!rst) begin
      sb.delete();
      exp_pc      = 16'h0000;
      discard     = 1'b0;
      outstanding = 1'b0;
      alive       = 1'b0;
      mem_cnt     = 0;
    end else begin
      if (imem_ack) mem_cnt = 0;
      else if (imem_req === 1'b1) mem_cnt++;
      if (alive && rv) begin
        if (imem_ack) begin
          discard = 1'b0;
        end else if (exp_req) begin
          if (!discard) held_pc = exp_pc;
          discard = 1'b1;
        end
        outstanding = exp_req && !imem_ack;
        exp_pc      = rp;
        sb.delete();
      end else if (imem_ack) begin
        if (discard) begin
          discard = 1'b0;
        end else begin
          sb.push_back('{mem_word(exp_pc), exp_pc, exp_pc + 16'd1});
          wrap_exp = (exp_pc == 16'hFFFF);
          exp_pc   = exp_pc + 16'd1;
        end
        outstanding = 1'b0;
      end else begin
        outstanding = exp_req;
      end
      alive = 1'b1;
    end
  endtask

  task automatic check_reset_outputs();
    @(posedge clk);
    #1;
    chk("rst_dec_valid", 16'(dec_valid), 16'h0000);
    chk("rst_imem_req", 16'(imem_req), 16'h0000);
    chk("rst_dec_instr", dec_instr, 16'h0000);
    chk("rst_dec_pc", dec_pc, 16'h0000);
    chk("rst_dec_pc_next", dec_pc_next, 16'h0000);
    chk("rst_pc_wrap", 16'(pc_wrap), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    nvec = 0; nerr = 0; lat = 0; mem_cnt = 0;
    exp_pc = 16'h0000; held_pc = 16'h0000; last_dec_pc = 16'h0000;
    discard = 1'b0; outstanding = 1'b0; alive = 1'b0; wrap_exp = 1'b0;
    valid_cnt = 0; wrap_cnt = 0;

    // Reset release, zero-latency stream, 4-cycle decode stall, resume.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0001};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0002};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0003};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0004};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0004};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0004};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0004};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0004};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0005};

    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check_reset_outputs();

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].rdy, 1'b0, 16'h0000);
      chk("tbl_req", 16'(imem_req), 16'(vecs[i].exp_req));
      chk("tbl_valid", 16'(dec_valid), 16'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk("tbl_dec_pc", dec_pc, vecs[i].exp_pc);
    end

    // Redirect to 0x0010, then memory answers 3 cycles late.
    step(1'b1, 1'b1, 1'b1, 16'h0010);
    lat = 3;
    valid_cnt = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("late_valid_pulses", 16'(valid_cnt), 16'd1);
    chk("late_dec_pc", last_dec_pc, 16'h0010);

    // Redirect to 0x0200 while 0x0011 is still outstanding.
    valid_cnt = 0;
    step(1'b1, 1'b1, 1'b1, 16'h0200);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    lat = 0;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("redir_gap_valid", 16'(valid_cnt), 16'd0);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("redir_dec_pc", last_dec_pc, 16'h0200);
    chk("redir_valid_pulses", 16'(valid_cnt), 16'd1);

    // Redirect while decode stalls, landing just below the wrap point.
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hFFFE);
    wrap_cnt = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("wrap_pulses", 16'(wrap_cnt), 16'd1);

    // Reset asserted while a slow fetch is outstanding.
    lat = 3;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    check_reset_outputs();
    lat = 0;
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("restart_idle_req", 16'(imem_req), 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("restart_addr", imem_addr, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    chk("restart_dec_pc", dec_pc, 16'h0000);
    repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
